// File: rtl/queue_param.sv
// Parametrised synchronous FIFO on the 10 kHz clock: arbitrary depth, optional
// first-word-fall-through output, threshold flags, sticky error flags and flush.
module queue_param #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 8,
    parameter bit FWFT         = 1'b0,
    parameter int AFULL_LEVEL  = DEPTH - 1,
    parameter int AEMPTY_LEVEL = 1,
    localparam int LW          = $clog2(DEPTH + 1)
) (
    input  logic             clk_10khz,
    input  logic             reset,
    input  logic             flush_in,
    input  logic             clear_err_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             enqueue_in,
    input  logic             dequeue_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic [LW-1:0]    len_out,
    output logic             full_out,
    output logic             empty_out,
    output logic             almost_full_out,
    output logic             almost_empty_out,
    output logic             overflow_out,
    output logic             underflow_out
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wp_r;
    logic [PW-1:0]    rp_r;
    logic [LW-1:0]    len_r;
    logic             overflow_r;
    logic             underflow_r;

    logic             empty_s;
    logic             full_s;
    logic             deq_ok_s;
    logic             enq_ok_s;
    logic             ovf_evt_s;
    logic             unf_evt_s;
    logic [31:0]      len_ext_s;

    // Pointers wrap by explicit compare so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign empty_s   = (len_r == {LW{1'b0}});
    assign full_s    = (len_r == LW'(DEPTH));
    assign deq_ok_s  = dequeue_in & ~empty_s;
    assign enq_ok_s  = enqueue_in & (~full_s | deq_ok_s);
    assign ovf_evt_s = enqueue_in & full_s & ~deq_ok_s & ~flush_in;
    assign unf_evt_s = dequeue_in & empty_s & ~flush_in;
    assign len_ext_s = 32'(len_r);

    // Pointer and occupancy update; flush overrides any request in the same cycle.
    always_ff @(posedge clk_10khz or negedge reset) begin
        if (!reset) begin
            wp_r  <= {PW{1'b0}};
            rp_r  <= {PW{1'b0}};
            len_r <= {LW{1'b0}};
        end else if (flush_in) begin
            wp_r  <= {PW{1'b0}};
            rp_r  <= {PW{1'b0}};
            len_r <= {LW{1'b0}};
        end else begin
            if (enq_ok_s) begin
                wp_r <= ptr_next(wp_r);
            end
            if (deq_ok_s) begin
                rp_r <= ptr_next(rp_r);
            end
            if (enq_ok_s && !deq_ok_s) begin
                len_r <= len_r + LW'(1);
            end else if (deq_ok_s && !enq_ok_s) begin
                len_r <= len_r - LW'(1);
            end
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk_10khz) begin
        if (enq_ok_s && !flush_in) begin
            mem_r[wp_r] <= data_in;
        end
    end

    // Sticky error flags; a new event wins over a coincident clear.
    always_ff @(posedge clk_10khz or negedge reset) begin
        if (!reset) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (ovf_evt_s) begin
                overflow_r <= 1'b1;
            end else if (clear_err_in) begin
                overflow_r <= 1'b0;
            end
            if (unf_evt_s) begin
                underflow_r <= 1'b1;
            end else if (clear_err_in) begin
                underflow_r <= 1'b0;
            end
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word shown directly; forced to zero when empty so reset reads clean.
            assign data_out  = empty_s ? {WIDTH{1'b0}} : mem_r[rp_r];
            assign valid_out = ~empty_s;
        end else begin : g_reg
            logic [WIDTH-1:0] data_r;
            logic             valid_r;

            // Registered read port: word captured and pulsed on each accepted dequeue.
            always_ff @(posedge clk_10khz or negedge reset) begin
                if (!reset) begin
                    data_r  <= {WIDTH{1'b0}};
                    valid_r <= 1'b0;
                end else if (flush_in) begin
                    data_r  <= {WIDTH{1'b0}};
                    valid_r <= 1'b0;
                end else begin
                    valid_r <= deq_ok_s;
                    if (deq_ok_s) begin
                        data_r <= mem_r[rp_r];
                    end
                end
            end

            assign data_out  = data_r;
            assign valid_out = valid_r;
        end
    endgenerate

    assign len_out          = len_r;
    assign full_out         = full_s;
    assign empty_out        = empty_s;
    assign almost_full_out  = (len_ext_s >= $unsigned(AFULL_LEVEL));
    assign almost_empty_out = (len_ext_s <= $unsigned(AEMPTY_LEVEL));
    assign overflow_out     = overflow_r;
    assign underflow_out    = underflow_r;

endmodule

// File: tb/tb_queue_param.sv
// Scoreboard bench: a registered-output DEPTH=8 queue and a FWFT DEPTH=5 queue
// driven by directed vectors; a monitor compares every presented word in order.
module tb_queue_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       rst_a, flush_a, clr_a, enq_a, deq_a;
    logic [7:0] din_a, dout_a;
    logic       valid_a, full_a, empty_a, afull_a, aempty_a, ovf_a, unf_a;
    logic [3:0] len_a;

    logic       rst_b, flush_b, clr_b, enq_b, deq_b;
    logic [7:0] din_b, dout_b;
    logic       valid_b, full_b, empty_b, afull_b, aempty_b, ovf_b, unf_b;
    logic [2:0] len_b;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    queue_param #(.WIDTH(8), .DEPTH(8), .FWFT(1'b0)) dut_a (
        .clk_10khz(clk), .reset(rst_a), .flush_in(flush_a), .clear_err_in(clr_a),
        .data_in(din_a), .enqueue_in(enq_a), .dequeue_in(deq_a),
        .data_out(dout_a), .valid_out(valid_a), .len_out(len_a),
        .full_out(full_a), .empty_out(empty_a),
        .almost_full_out(afull_a), .almost_empty_out(aempty_a),
        .overflow_out(ovf_a), .underflow_out(unf_a)
    );

    queue_param #(.WIDTH(8), .DEPTH(5), .FWFT(1'b1)) dut_b (
        .clk_10khz(clk), .reset(rst_b), .flush_in(flush_b), .clear_err_in(clr_b),
        .data_in(din_b), .enqueue_in(enq_b), .dequeue_in(deq_b),
        .data_out(dout_b), .valid_out(valid_b), .len_out(len_b),
        .full_out(full_b), .empty_out(empty_b),
        .almost_full_out(afull_b), .almost_empty_out(aempty_b),
        .overflow_out(ovf_b), .underflow_out(unf_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the expected word whenever a queue presents output.
    always @(negedge clk) begin
        if (rst_a && valid_a) begin
            if (exp_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_valid: actual data %0h required no valid", dout_a);
            end else begin
                check("a_deq_data", 32'(dout_a), 32'(exp_a.pop_front()));
            end
        end
        if (rst_b && valid_b && deq_b) begin
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_deq: actual head %0h required nothing pending", dout_b);
            end else begin
                check("b_head_data", 32'(dout_b), 32'(exp_b.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] fill_v  [8] = '{8'hA5, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        logic [7:0] drain_v [7] = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h77};
        logic [7:0] head_v  [12] = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22,
                                     8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};

        rst_a = 1'b0; flush_a = 1'b0; clr_a = 1'b0; enq_a = 1'b0; deq_a = 1'b0; din_a = 8'h00;
        rst_b = 1'b0; flush_b = 1'b0; clr_b = 1'b0; enq_b = 1'b0; deq_b = 1'b0; din_b = 8'h00;
        #12;
        check("a_rst_data",   32'(dout_a),   32'h0);
        check("a_rst_valid",  32'(valid_a),  32'h0);
        check("a_rst_len",    32'(len_a),    32'h0);
        check("a_rst_empty",  32'(empty_a),  32'h1);
        check("a_rst_aempty", 32'(aempty_a), 32'h1);
        check("a_rst_full",   32'(full_a),   32'h0);
        check("a_rst_afull",  32'(afull_a),  32'h0);
        check("a_rst_err",    32'({ovf_a, unf_a}), 32'h0);
        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Fill
        enq_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din_a = fill_v[i];
            cyc();
            check("fill_len",    32'(len_a),   32'(i + 1));
            check("fill_afull",  32'(afull_a), 32'(i + 1 >= 7));
            check("fill_full",   32'(full_a),  32'(i == 7));
            check("fill_empty",  32'(empty_a), 32'h0);
            check("fill_aempty", 32'(aempty_a), 32'(i == 0));
        end

        // Overflow, then clear
        din_a = 8'hFF;
        cyc();
        enq_a = 1'b0;
        check("ovf_len",  32'(len_a), 32'h8);
        check("ovf_flag", 32'(ovf_a), 32'h1);
        clr_a = 1'b1;
        cyc();
        clr_a = 1'b0;
        check("ovf_clear", 32'(ovf_a), 32'h0);

        // Single dequeue
        deq_a = 1'b1;
        exp_a.push_back(8'hA5);
        cyc();
        deq_a = 1'b0;
        check("deq1_len", 32'(len_a), 32'h7);
        cyc();

        // Simultaneous enqueue/dequeue, then drain
        enq_a = 1'b1; din_a = 8'h77; deq_a = 1'b1;
        exp_a.push_back(8'h02);
        cyc();
        enq_a = 1'b0;
        check("simul_len", 32'(len_a), 32'h7);
        for (int i = 0; i < 7; i++) begin
            exp_a.push_back(drain_v[i]);
            cyc();
            check("drain_len", 32'(len_a), 32'(6 - i));
        end
        check("drain_empty", 32'(empty_a), 32'h1);
        cyc();
        deq_a = 1'b0;
        check("unf_flag", 32'(unf_a), 32'h1);
        check("unf_len",  32'(len_a), 32'h0);
        cyc();
        check("unf_data_hold", 32'(dout_a),  32'h77);
        check("unf_valid",     32'(valid_a), 32'h0);
        clr_a = 1'b1;
        cyc();
        clr_a = 1'b0;
        check("unf_clear", 32'(unf_a), 32'h0);

        // Full plus simultaneous
        enq_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din_a = 8'h11 + 8'(i);
            cyc();
        end
        din_a = 8'h99; deq_a = 1'b1;
        exp_a.push_back(8'h11);
        cyc();
        deq_a = 1'b0;
        check("full_simul_len",  32'(len_a),  32'h8);
        check("full_simul_ovf",  32'(ovf_a),  32'h0);
        check("full_simul_full", 32'(full_a), 32'h1);
        din_a = 8'hAA; clr_a = 1'b1;
        cyc();
        enq_a = 1'b0; clr_a = 1'b0;
        check("set_wins_ovf", 32'(ovf_a), 32'h1);

        // Flush with a dequeue pending
        flush_a = 1'b1; deq_a = 1'b1;
        cyc();
        flush_a = 1'b0; deq_a = 1'b0;
        check("a_flush_len",   32'(len_a),   32'h0);
        check("a_flush_data",  32'(dout_a),  32'h0);
        check("a_flush_valid", 32'(valid_a), 32'h0);
        check("a_flush_unf",   32'(unf_a),   32'h0);
        check("a_flush_ovf",   32'(ovf_a),   32'h1);

        // Empty queue, both requested
        enq_a = 1'b1; din_a = 8'h5A; deq_a = 1'b1;
        cyc();
        enq_a = 1'b0; deq_a = 1'b0;
        check("empty_both_len", 32'(len_a), 32'h1);
        check("empty_both_unf", 32'(unf_a), 32'h1);
        clr_a = 1'b1; deq_a = 1'b1;
        exp_a.push_back(8'h5A);
        cyc();
        clr_a = 1'b0; deq_a = 1'b0;
        check("empty_both_clear", 32'({ovf_a, unf_a}), 32'h0);
        check("empty_both_len2",  32'(len_a), 32'h0);
        cyc();

        // FWFT, DEPTH=5
        enq_b = 1'b1; din_b = 8'h10;
        cyc();
        check("b_head_immediate", 32'(dout_b),  32'h10);
        check("b_valid",          32'(valid_b), 32'h1);
        check("b_len1",           32'(len_b),   32'h1);
        din_b = 8'h11;
        cyc();
        din_b = 8'h12;
        cyc();
        check("b_len3",      32'(len_b),  32'h3);
        check("b_head_keep", 32'(dout_b), 32'h10);
        deq_b = 1'b1;
        for (int i = 0; i < 12; i++) begin
            din_b = 8'h20 + 8'(i);
            exp_b.push_back(head_v[i]);
            cyc();
            check("b_wrap_len", 32'(len_b), 32'h3);
        end
        enq_b = 1'b0; deq_b = 1'b0;
        check("b_next_head", 32'(dout_b), 32'h29);

        flush_b = 1'b1; enq_b = 1'b1; din_b = 8'hEE;
        cyc();
        flush_b = 1'b0; enq_b = 1'b0;
        check("b_flush_len",   32'(len_b),   32'h0);
        check("b_flush_empty", 32'(empty_b), 32'h1);
        check("b_flush_valid", 32'(valid_b), 32'h0);
        check("b_flush_err",   32'({ovf_b, unf_b}), 32'h0);
        enq_b = 1'b1; din_b = 8'h33;
        cyc();
        check("b_after_flush_head", 32'(dout_b), 32'h33);
        check("b_after_flush_len",  32'(len_b),  32'h1);
        for (int i = 0; i < 5; i++) begin
            din_b = 8'h44 + 8'(i * 17);
            cyc();
        end
        enq_b = 1'b0;
        check("b_pre_rst_full", 32'(full_b), 32'h1);
        check("b_pre_rst_ovf",  32'(ovf_b),  32'h1);

        // Asynchronous reset between edges
        #3;
        rst_b = 1'b0;
        #1;
        check("b_rst_data",   32'(dout_b),   32'h0);
        check("b_rst_valid",  32'(valid_b),  32'h0);
        check("b_rst_len",    32'(len_b),    32'h0);
        check("b_rst_empty",  32'(empty_b),  32'h1);
        check("b_rst_aempty", 32'(aempty_b), 32'h1);
        check("b_rst_full",   32'(full_b),   32'h0);
        check("b_rst_afull",  32'(afull_b),  32'h0);
        check("b_rst_err",    32'({ovf_b, unf_b}), 32'h0);
        @(negedge clk);
        rst_b = 1'b1;
        cyc();

        check("a_pending_words", 32'(exp_a.size()), 32'h0);
        check("b_pending_words", 32'(exp_b.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/queue_param.md
# queue_param

Parametrised synchronous FIFO queue, successor to the fixed 8×8-bit queue in the `clk_10khz` domain. It adds configurable width and depth, including depths that are not a power of two, and a selectable output mode: registered-on-dequeue or first-word-fall-through. It also adds almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. It buffers data between producer and consumer logic on the same 10 kHz clock.

## Interface
- `WIDTH`, 8, data word width in bits (≥1)
- `DEPTH`, 8, number of entries (≥2, any integer)
- `FWFT`, 0, output mode: 0 = registered-on-dequeue, 1 = first-word-fall-through
- `AFULL_LEVEL`, DEPTH-1, `almost_full_out` asserts when len ≥ this value
- `AEMPTY_LEVEL`, 1, `almost_empty_out` asserts when len ≤ this value
- `LW` (derived), $clog2(DEPTH+1), width of the length count

Ports:
- `clk_10khz`  in  1  single clock; everything is sampled on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `flush_in`  in  1  synchronous queue clear
- `clear_err_in`  in  1  synchronous clear of the sticky error flags
- `data_in`  in  WIDTH  word to enqueue
- `enqueue_in`  in  1  enqueue request
- `dequeue_in`  in  1  dequeue request
- `data_out`  out  WIDTH  dequeued word (FWFT=0) or head word (FWFT=1)
- `valid_out`  out  1  FWFT=0: one-cycle pulse after an accepted dequeue; FWFT=1: high when not empty
- `len_out`  out  LW  current occupancy, 0..DEPTH
- `full_out`, `empty_out`  out  1  len==DEPTH / len==0
- `almost_full_out`, `almost_empty_out`  out  1  threshold flags
- `overflow_out`, `underflow_out`  out  1  sticky error flags

## Operation
- **Storage:** circular buffer with write pointer `wp` and read pointer `rp`. Each pointer wraps from DEPTH-1 to 0 by explicit compare, not by power-of-two truncation. `len` is a registered counter.
- **Dequeue acceptance:** `deq_ok` = `dequeue_in` & len≠0.
- **Enqueue acceptance:** `enq_ok` = `enqueue_in` & (len≠DEPTH | `deq_ok`). Enqueue and dequeue on a full queue are both accepted, and len stays at DEPTH.
- **Length update:** len += `enq_ok` − `deq_ok`. Simultaneous accepted enqueue and dequeue leaves len unchanged.
- **Empty queue, both requested:** only the enqueue is accepted, and the underflow flag is set.
- **Overflow:** `enqueue_in` while full without `deq_ok`. The word is dropped, memory and pointers are unchanged, and `overflow_out` is set.
- **Underflow:** `dequeue_in` while empty. Nothing changes except that `underflow_out` is set. `data_out` holds its value.
- **Error flag lifetime:** both error flags stay set until `clear_err_in` or reset. If `clear_err_in` coincides with a new error event, the flag ends up set (the set wins).
- **FWFT=0 output:** on `deq_ok`, `data_out` ← mem[rp] at the edge, and `valid_out` pulses high for one cycle. Otherwise `data_out` holds.
- **FWFT=1 output:** `data_out` = mem[rp] combinationally. It shows the head whenever len≠0 and is don't-care when empty. `valid_out` = !`empty_out`.
- **Flush:** `flush_in` has priority over enqueue and dequeue in the same cycle. It sets `wp`, `rp` and len to 0 and sets `data_out` to 0 (FWFT=0). It does not touch the error flags. An enqueue or dequeue in the flush cycle is ignored and flags no error.
- **Status flags:** all status flags are decoded combinationally from the registered len.
- **Reset values:** `data_out`=0, `valid_out`=0, `len_out`=0, `empty_out`=1, `almost_empty_out`=1 (given AEMPTY_LEVEL ≥ 0), `full_out`=0, `almost_full_out`=0, `overflow_out`=0, `underflow_out`=0, pointers 0. Memory is not reset.

## Timing
- **Sampling:** requests are sampled at the rising edge. `len_out` and all status flags reflect that edge immediately after it, with no extra latency.
- **FWFT=0 latency:** `data_out` is valid one cycle after the dequeue request edge, coincident with the `valid_out` pulse.
- **FWFT=1 latency:** a word enqueued into an empty queue appears on `data_out` right after the enqueue edge. After an accepted dequeue, the next head appears right after that edge.
- **Reset mid-operation:** asserting `reset` low forces all outputs to their reset values asynchronously, without waiting for a clock edge. Deassertion is synchronised externally. The first operation is accepted at the first edge with `reset` high.
- **Throughput:** back-to-back enqueue and dequeue every cycle is supported with no bubbles.

## Test plan
1. **Fill:** reset, then enqueue A5, 02..08 on 8 consecutive cycles (DEPTH=8). Required: len_out 1..8, `almost_full_out` from len 7, `full_out`=1 after the 8th, `empty_out`=0 after the 1st.
2. **Overflow:** enqueue FF while full. Required: len_out stays 8, `overflow_out`=1, and FF never appears in any later output. Then pulse `clear_err_in`: required `overflow_out`=0.
3. **Single dequeue (FWFT=0):** one dequeue. Required: `data_out`=A5 with a one-cycle `valid_out` pulse, and len_out=7.
4. **Simultaneous, then drain:** enqueue 77 and dequeue together. Required: `data_out`=02, len_out=7. Then drain 7 words. Required output order 03, 04, 05, 06, 07, 08, 77, ending with `empty_out`=1. One extra dequeue: required `underflow_out`=1 and `data_out` holds 77.
5. **Full plus simultaneous:** at len=8, enqueue and dequeue together. Required: both accepted, len_out stays 8, `overflow_out`=0.
6. **FWFT=1, DEPTH=5, flush and reset:** run 12 enqueue/dequeue cycles that wrap the pointers. Required: data order preserved and the head is visible with no dequeue latency. Then flush at len 3 while enqueue is asserted: required len_out=0, `empty_out`=1, no error flag. Then drive `reset` low between clock edges: required all outputs at their reset values immediately.
